// File: rtl/wifi_uart_pkg.sv
// Shared types and line-timing constants for the Wi-Fi UART receive path.
package wifi_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   localparam int TICKS_PER_BIT  = 16;
   localparam int MID_START_TICK = 7;

   typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO: dout is the head entry whenever empty is low.
module uart_rx_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level,
   output logic [LW-1:0]    level_nxt
);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   always_comb begin
      full     = (level_q == LW'(DEPTH));
      empty    = (level_q == '0);
      pop_ok   = pop & ~empty;
      // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
      push_ok  = push & (~full | pop_ok);
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push_ok && !pop_ok) begin
         level_d = level_q + LW'(1);
      end else if (!push_ok && pop_ok) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout      = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign level_nxt = level_d;

endmodule

// File: rtl/wifi_uart_rx_fc.sv
// 8N1 UART receiver with FIFO and RTS flow control for the Wi-Fi module link.
// Even parity bit is added when WIFI_UART_RX_PARITY_EN is defined.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | checking start bit at mid-bit
//   DATA      | shifting in 8 data bits, LSB first
//   PARITY    | sampling the even-parity bit
//   STOP      | sampling stop bit, push or flag the byte
//   WAIT_IDLE | framing error seen, wait for line high
module wifi_uart_rx_fc
   import wifi_uart_pkg::*;
#(
   parameter int CLKS_PER_TICK = 27,
   parameter int FIFO_DEPTH    = 16,
   parameter int RTS_MARGIN    = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              rxd,
   output logic                              rts_n,
   output logic [7:0]                        out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
   output logic                              frame_err,
   output logic                              overrun,
   output logic                              parity_err
);

   localparam int              LW           = $clog2(FIFO_DEPTH + 1);
   localparam int              TW           = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [LW-1:0]   RTS_THR      = LW'(FIFO_DEPTH - RTS_MARGIN);
   localparam logic [3:0]      START_SAMPLE = 4'(MID_START_TICK);
   localparam logic [3:0]      BIT_SAMPLE   = 4'(TICKS_PER_BIT - 1);

   logic          rxd_meta_q, rxd_meta_d;
   logic          rxd_s_q, rxd_s_d;
   logic [1:0]    sync_vld_q, sync_vld_d;
   logic          armed_q, armed_d;
   state_t        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]    sub_cnt_q, sub_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   byte_t         shift_q, shift_d;
   logic          rts_n_q, rts_n_d;
   logic          tick, bit_end, push, pop, fifo_full, fifo_empty, par_ok;
   logic [LW-1:0] level_nxt;

`ifdef WIFI_UART_RX_PARITY_EN
   logic par_bit_q, par_bit_d;
   assign par_ok = (par_bit_q == ^shift_q);
`else
   assign par_ok = 1'b1;
`endif

   // Arming needs a genuine high on rxd_s after reset, so a frame cut by reset is never resumed.
   always_comb begin
      rxd_meta_d = rxd;
      rxd_s_d    = rxd_meta_q;
      sync_vld_d = {sync_vld_q[0], 1'b1};
      armed_d    = armed_q | (sync_vld_q[1] & rxd_s_q);
      rts_n_d    = (level_nxt >= RTS_THR);
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      sub_cnt_d  = sub_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      push       = 1'b0;
      frame_err  = 1'b0;
      parity_err = 1'b0;
`ifdef WIFI_UART_RX_PARITY_EN
      par_bit_d  = par_bit_q;
`endif
      tick    = (tick_cnt_q == TW'(CLKS_PER_TICK - 1));
      bit_end = tick && (sub_cnt_q == BIT_SAMPLE);
      if (state_q != IDLE) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
         if (tick) sub_cnt_d = sub_cnt_q + 4'd1;
      end

      case (state_q)
         IDLE: begin
            tick_cnt_d = '0;
            sub_cnt_d  = '0;
            if (armed_q && !rxd_s_q) state_d = START;
         end
         START: begin
            if (tick && sub_cnt_q == START_SAMPLE) begin
               if (rxd_s_q) begin
                  state_d = IDLE;
               end else begin
                  state_d    = DATA;
                  bit_idx_d  = '0;
                  tick_cnt_d = '0;
                  sub_cnt_d  = '0;
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = {rxd_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef WIFI_UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef WIFI_UART_RX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               par_bit_d = rxd_s_q;
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               push       = rxd_s_q & par_ok;
               frame_err  = ~rxd_s_q;
`ifdef WIFI_UART_RX_PARITY_EN
               parity_err = ~par_ok;
`endif
               state_d    = rxd_s_q ? IDLE : WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (rxd_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         sync_vld_q <= '0;
         armed_q    <= 1'b0;
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         sub_cnt_q  <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         rts_n_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd_meta_d;
         rxd_s_q    <= rxd_s_d;
         sync_vld_q <= sync_vld_d;
         armed_q    <= armed_d;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         sub_cnt_q  <= sub_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         rts_n_q    <= rts_n_d;
      end
   end

`ifdef WIFI_UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) par_bit_q <= 1'b0;
      else       par_bit_q <= par_bit_d;
   end
`endif

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(byte_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .din       (shift_q),
      .dout      (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level),
      .level_nxt (level_nxt)
   );

   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign overrun   = push & fifo_full & ~pop;
   assign rts_n     = rts_n_q;

endmodule
